// File: rtl/cmd_fetch_decoder.sv
// rtl/cmd_fetch_decoder.sv - instruction BRAM command stream fetcher and decoder
//
// Walks the command stream held in the instruction BRAM, starting at base_addr
// and ending at a Flush command. Emits decoded headers and operand beats to
// the pipeline over valid/ready handshakes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr      start pulse (IDLE/HALT only) and first header index
//   addr1 / read0         header read address and combinational BRAM data
//   addr2 / read1..read4  operand read address and mem[addr2+0..3]
//   cmd_*                 decoded header handshake (opcode, imm, count)
//   op_*                  operand beat handshake (128-bit data, nwords, last)
//   busy, done, error     status; done/error held until next start or reset
//   fetch_pc              current word index
module cmd_fetch_decoder #(
  parameter int          MEM_DEPTH    = 45,
  parameter int          MAX_OPERANDS = 16,
  parameter logic [7:0]  FLUSH_OP     = 8'h05
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   base_addr,
  output logic [31:0]   addr1,
  output logic [31:0]   addr2,
  input  logic [31:0]   read0,
  input  logic [31:0]   read1,
  input  logic [31:0]   read2,
  input  logic [31:0]   read3,
  input  logic [31:0]   read4,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd_opcode,
  output logic [7:0]    cmd_imm,
  output logic [4:0]    cmd_count,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [127:0]  op_data,
  output logic [2:0]    op_nwords,
  output logic          op_last,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [31:0]   fetch_pc
);

  typedef enum logic [2:0] {IDLE, HDR, CMD, OPER, HALT} state_t;

  state_t       state, state_next;
  logic [31:0]  pc, pc_next;
  logic [4:0]   remaining, remaining_next;
  logic         done_next, error_next, load_cmd;

  // Header decode
  logic         hdr_is_op;
  logic [7:0]   hdr_cnt;
  logic [32:0]  hdr_end;
  logic         hdr_bad;
  logic         unused_hdr_bits;

  // Beat sizing
  logic [2:0]   beat_words;
  logic         beat_last;

  assign hdr_is_op = read0[31];
  assign hdr_cnt   = read0[15:8];
  // One past the last operand word; 33 bits so a huge pc cannot wrap.
  assign hdr_end   = {1'b0, pc} + 33'd1 + {25'd0, hdr_cnt};
  assign hdr_bad   = (pc >= 32'(MEM_DEPTH)) ||
                     (hdr_is_op && ((hdr_cnt == 8'd0) ||
                                    (hdr_cnt > 8'(MAX_OPERANDS)) ||
                                    (hdr_end > 33'(MEM_DEPTH))));
  // Header bits 30:16 carry no meaning for this block.
  assign unused_hdr_bits = ^read0[30:16];

  assign beat_words = (remaining >= 5'd4) ? 3'd4 : remaining[2:0];
  assign beat_last  = (remaining <= 5'd4);

  assign addr1     = pc;
  assign addr2     = pc;
  assign fetch_pc  = pc;
  assign cmd_valid = (state == CMD);
  assign op_valid  = (state == OPER);
  assign busy      = (state == HDR) || (state == CMD) || (state == OPER);
  assign op_nwords = op_valid ? beat_words : 3'd0;
  assign op_last   = op_valid && beat_last;

  // Lanes beyond op_nwords are zeroed so the consumer never sees the next header.
  always_comb begin
    op_data = '0;
    if (op_valid) begin
      op_data[127:96] = read1;
      if (beat_words >= 3'd2) op_data[95:64] = read2;
      if (beat_words >= 3'd3) op_data[63:32] = read3;
      if (beat_words == 3'd4) op_data[31:0]  = read4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    remaining_next = remaining;
    done_next      = done;
    error_next     = error;
    load_cmd       = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_next    = base_addr;
          done_next  = 1'b0;
          error_next = 1'b0;
          state_next = HDR;
        end
      end
      HDR: begin
        if (hdr_bad) begin
          error_next = 1'b1;
          state_next = HALT;
        end else begin
          load_cmd   = 1'b1;
          state_next = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          pc_next = pc + 32'd1;
          // Operand commands always carry a nonzero count; immediates carry 0.
          if (cmd_count != 5'd0) begin
            remaining_next = cmd_count;
            state_next     = OPER;
          end else if (cmd_opcode == FLUSH_OP) begin
            done_next  = 1'b1;
            state_next = HALT;
          end else begin
            state_next = HDR;
          end
        end
      end
      OPER: begin
        if (op_ready) begin
          pc_next        = pc + {29'd0, beat_words};
          remaining_next = remaining - {2'd0, beat_words};
          if (beat_last) state_next = HDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      remaining  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cmd_opcode <= '0;
      cmd_imm    <= '0;
      cmd_count  <= '0;
    end else begin
      pc        <= pc_next;
      remaining <= remaining_next;
      done      <= done_next;
      error     <= error_next;
      if (load_cmd) begin
        cmd_opcode <= read0[7:0];
        cmd_imm    <= hdr_is_op ? 8'd0 : read0[15:8];
        cmd_count  <= hdr_is_op ? read0[12:8] : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_fetch_decoder.sv
// tb/tb_cmd_fetch_decoder.sv - directed self-checking bench for cmd_fetch_decoder
module tb_cmd_fetch_decoder;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [31:0]   base_addr, addr1, addr2;
  logic [31:0]   read0, read1, read2, read3, read4;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_opcode, cmd_imm;
  logic [4:0]    cmd_count;
  logic          op_valid, op_ready;
  logic [127:0]  op_data;
  logic [2:0]    op_nwords;
  logic          op_last, busy, done, error;
  logic [31:0]   fetch_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:63];
  logic [31:0] a2p1, a2p2, a2p3;

  assign a2p1  = addr2 + 32'd1;
  assign a2p2  = addr2 + 32'd2;
  assign a2p3  = addr2 + 32'd3;
  assign read0 = (addr1 < 32'd64) ? mem[addr1[5:0]] : 32'h0;
  assign read1 = (addr2 < 32'd64) ? mem[addr2[5:0]] : 32'h0;
  assign read2 = (a2p1  < 32'd64) ? mem[a2p1[5:0]]  : 32'h0;
  assign read3 = (a2p2  < 32'd64) ? mem[a2p2[5:0]]  : 32'h0;
  assign read4 = (a2p3  < 32'd64) ? mem[a2p3[5:0]]  : 32'h0;

  always #5 clk = ~clk;

  cmd_fetch_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .addr1(addr1), .addr2(addr2),
    .read0(read0), .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_imm(cmd_imm), .cmd_count(cmd_count),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .op_nwords(op_nwords), .op_last(op_last),
    .busy(busy), .done(done), .error(error), .fetch_pc(fetch_pc)
  );

  // Demo program header table: opcode, imm, count, pc
  logic [7:0]  exp_op  [0:8] = '{8'h10, 8'h11, 8'h04, 8'h03, 8'h04, 8'h03, 8'h04, 8'h03, 8'h05};
  logic [7:0]  exp_imm [0:8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [4:0]  exp_cnt [0:8] = '{5'd0, 5'd16, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd0};
  logic [31:0] exp_pc  [0:8] = '{32'd0, 32'd1, 32'd18, 32'd22, 32'd26, 32'd30, 32'd34, 32'd38, 32'd42};

  task automatic load_demo();
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
    mem[0]  = 32'h0000_0110;
    mem[1]  = 32'h8000_1011;
    mem[2]  = 32'h3F35_04F3; mem[3]  = 32'h0; mem[4] = 32'hBF35_04F2; mem[5] = 32'h0;
    mem[14] = 32'h0; mem[15] = 32'h0; mem[16] = 32'h0; mem[17] = 32'h3F80_0000;
    mem[18] = 32'h8000_0304;
    mem[19] = 32'h3F80_0000; mem[20] = 32'h0; mem[21] = 32'h0;
    mem[22] = 32'h8000_0303; mem[26] = 32'h8000_0304; mem[30] = 32'h8000_0303;
    mem[34] = 32'h8000_0304; mem[38] = 32'h8000_0303;
    mem[42] = 32'h0000_0005;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic pulse_start(input logic [31:0] b);
    base_addr = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; cmd_ready = 1'b0; op_ready = 1'b0;
    load_demo();
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b want=000", {busy, done, error}); end
    n_cmp++; if ({cmd_valid, op_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids got=%b want=00", {cmd_valid, op_valid}); end
    n_cmp++; if (fetch_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%0d want=0", fetch_pc); end
    n_cmp++; if ({addr1, addr2} !== 64'd0) begin n_fail++; $display("FAIL reset_addr got=%h/%h want=0/0", addr1, addr2); end
    n_cmp++; if ({cmd_opcode, cmd_imm, cmd_count} !== 21'd0) begin n_fail++; $display("FAIL reset_cmd got=%h/%h/%h want=0", cmd_opcode, cmd_imm, cmd_count); end
    n_cmp++; if ({op_data, op_nwords, op_last} !== 132'd0) begin n_fail++; $display("FAIL reset_op got=%h/%0d/%b want=0", op_data, op_nwords, op_last); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cmd_backpressure();
    do_reset();
    cmd_ready = 1'b0; op_ready = 1'b0;
    pulse_start(32'd0);
    n_cmp++; if ({busy, cmd_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_hdr_cycle busy/valid got=%b want=10", {busy, cmd_valid}); end
    @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_latency cmd_valid got=%b want=1", cmd_valid); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({cmd_valid, cmd_opcode, cmd_imm, cmd_count, fetch_pc} !== {1'b1, 8'h10, 8'h01, 5'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got=%b/%h/%h/%0d pc=%0d want=1/10/01/0 pc=0", i, cmd_valid, cmd_opcode, cmd_imm, cmd_count, fetch_pc);
      end
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    n_cmp++; if ({cmd_valid, fetch_pc} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL bp_accept got=%b pc=%0d want=0 pc=1", cmd_valid, fetch_pc); end
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_opcode, cmd_imm, cmd_count} !== {1'b1, 8'h11, 8'h00, 5'd16}) begin n_fail++; $display("FAIL bp_second_hdr got=%b/%h/%h/%0d want=1/11/00/16", cmd_valid, cmd_opcode, cmd_imm, cmd_count); end
  endtask

  task automatic test_demo();
    int          nh, nb, cyc, q, rem, n, eb_n;
    logic [7:0]  r_op [0:15];
    logic [7:0]  r_imm [0:15];
    logic [4:0]  r_cnt [0:15];
    logic [31:0] r_pc [0:15];
    logic [127:0] b_data [0:15];
    logic [2:0]  b_nw [0:15];
    logic        b_last [0:15];
    logic [31:0] b_pc [0:15];
    logic [127:0] e_data [0:15];
    logic [2:0]  e_nw [0:15];
    logic        e_last [0:15];
    logic [31:0] e_pc [0:15];
    logic [127:0] d;
    nh = 0; nb = 0; cyc = 0; eb_n = 0;
    do_reset();
    load_demo();
    cmd_ready = 1'b1; op_ready = 1'b1;
    pulse_start(32'd0);
    while (busy === 1'b1 && cyc < 200) begin
      if (cmd_valid === 1'b1 && nh < 16) begin
        r_op[nh] = cmd_opcode; r_imm[nh] = cmd_imm; r_cnt[nh] = cmd_count; r_pc[nh] = fetch_pc; nh++;
      end
      if (op_valid === 1'b1 && nb < 16) begin
        b_data[nb] = op_data; b_nw[nb] = op_nwords; b_last[nb] = op_last; b_pc[nb] = fetch_pc; nb++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (cyc >= 200) begin n_fail++; $display("FAIL demo_timeout cycles=%0d want<200", cyc); end
    n_cmp++; if (nh != 9) begin n_fail++; $display("FAIL demo_hdr_count got=%0d want=9", nh); end
    for (int i = 0; i < 9 && i < nh; i++) begin
      n_cmp++;
      if ({r_op[i], r_imm[i], r_cnt[i], r_pc[i]} !== {exp_op[i], exp_imm[i], exp_cnt[i], exp_pc[i]}) begin
        n_fail++;
        $display("FAIL demo_hdr[%0d] got=%h/%h/%0d pc=%0d want=%h/%h/%0d pc=%0d", i, r_op[i], r_imm[i], r_cnt[i], r_pc[i], exp_op[i], exp_imm[i], exp_cnt[i], exp_pc[i]);
      end
    end
    // Expected beats: operands follow each header in chunks of up to four words.
    for (int h = 0; h < 9; h++) begin
      if (exp_cnt[h] != 5'd0) begin
        q = int'(exp_pc[h]) + 1; rem = int'(exp_cnt[h]);
        while (rem > 0) begin
          n = (rem > 4) ? 4 : rem;
          d = '0;
          for (int k = 0; k < n; k++) d[127 - 32*k -: 32] = mem[q + k];
          e_data[eb_n] = d; e_nw[eb_n] = 3'(n); e_last[eb_n] = (rem <= 4); e_pc[eb_n] = 32'(q);
          eb_n++; q += n; rem -= n;
        end
      end
    end
    n_cmp++; if (nb != eb_n) begin n_fail++; $display("FAIL demo_beat_count got=%0d want=%0d", nb, eb_n); end
    for (int j = 0; j < eb_n && j < nb; j++) begin
      n_cmp++;
      if ({b_data[j], b_nw[j], b_last[j], b_pc[j]} !== {e_data[j], e_nw[j], e_last[j], e_pc[j]}) begin
        n_fail++;
        $display("FAIL demo_beat[%0d] got=%h/%0d/%b pc=%0d want=%h/%0d/%b pc=%0d", j, b_data[j], b_nw[j], b_last[j], b_pc[j], e_data[j], e_nw[j], e_last[j], e_pc[j]);
      end
    end
    if (nb >= 5) begin
      n_cmp++; if (b_data[0] !== 128'h3F3504F3_00000000_BF3504F2_00000000) begin n_fail++; $display("FAIL rotate_first got=%h", b_data[0]); end
      n_cmp++; if (b_data[3] !== 128'h00000000_00000000_00000000_3F800000) begin n_fail++; $display("FAIL rotate_last got=%h", b_data[3]); end
      n_cmp++; if ({b_nw[0], b_nw[1], b_nw[2], b_nw[3]} !== {3'd4, 3'd4, 3'd4, 3'd4}) begin n_fail++; $display("FAIL rotate_nwords got=%0d,%0d,%0d,%0d want=4,4,4,4", b_nw[0], b_nw[1], b_nw[2], b_nw[3]); end
      n_cmp++; if ({b_last[0], b_last[1], b_last[2], b_last[3]} !== 4'b0001) begin n_fail++; $display("FAIL rotate_last_flags got=%b want=0001", {b_last[0], b_last[1], b_last[2], b_last[3]}); end
      n_cmp++; if ({b_data[4], b_nw[4], b_last[4]} !== {128'h3F800000_00000000_00000000_00000000, 3'd3, 1'b1}) begin n_fail++; $display("FAIL color_beat got=%h/%0d/%b want=3F800000_0_0_0/3/1", b_data[4], b_nw[4], b_last[4]); end
    end
    n_cmp++; if ({done, busy, error, fetch_pc} !== {1'b1, 1'b0, 1'b0, 32'd43}) begin n_fail++; $display("FAIL demo_finish done/busy/error=%b pc=%0d want=100 pc=43", {done, busy, error}, fetch_pc); end
  endtask

  task automatic test_op_backpressure();
    int cyc;
    do_reset();
    cmd_ready = 1'b1; op_ready = 1'b0;
    pulse_start(32'd0);
    cyc = 0;
    while (op_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_cmp++; if ({op_valid, fetch_pc, op_data} !== {1'b1, 32'd2, 128'h3F3504F3_00000000_BF3504F2_00000000}) begin n_fail++; $display("FAIL opbp_first got=%b pc=%0d data=%h", op_valid, fetch_pc, op_data); end
    op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({op_valid, fetch_pc, op_data, op_last} !== {1'b1, 32'd6, 128'h20000006_20000007_20000008_20000009, 1'b0}) begin
        n_fail++;
        $display("FAIL opbp_hold[%0d] got=%b pc=%0d data=%h last=%b want=1 pc=6 data=20000006_..09 last=0", i, op_valid, fetch_pc, op_data, op_last);
      end
      @(negedge clk);
    end
    op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
    n_cmp++; if ({fetch_pc, op_data} !== {32'd10, 128'h2000000A_2000000B_2000000C_2000000D}) begin n_fail++; $display("FAIL opbp_next got pc=%0d data=%h want pc=10 data=2000000A_..0D", fetch_pc, op_data); end
    op_ready = 1'b1; @(negedge clk); op_ready = 1'b0;
    n_cmp++; if ({fetch_pc, op_last, op_data} !== {32'd14, 1'b1, 128'h00000000_00000000_00000000_3F800000}) begin n_fail++; $display("FAIL opbp_final got pc=%0d last=%b data=%h", fetch_pc, op_last, op_data); end
  endtask

  task automatic test_malformed();
    int seen;
    do_reset();
    load_demo();
    mem[0] = 32'h8000_1111;
    cmd_ready = 1'b1; op_ready = 1'b1;
    pulse_start(32'd0);
    seen = (cmd_valid === 1'b1) ? 1 : 0;
    @(negedge clk);
    n_cmp++; if ({error, busy, done} !== 3'b100) begin n_fail++; $display("FAIL bad_count error/busy/done got=%b want=100", {error, busy, done}); end
    repeat (3) begin if (cmd_valid === 1'b1) seen++; @(negedge clk); end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL bad_count_cmd_valid got=%0d cycles want=0", seen); end
    mem[0] = 32'h0000_0110;
    // Restart from HALT onto a header whose operands run past the memory end.
    mem[43] = 32'h8000_0303;
    pulse_start(32'd43);
    n_cmp++; if ({error, busy, fetch_pc} !== {1'b0, 1'b1, 32'd43}) begin n_fail++; $display("FAIL overrun_restart error/busy=%b pc=%0d want=01 pc=43", {error, busy}, fetch_pc); end
    @(negedge clk);
    n_cmp++; if ({error, busy, cmd_valid} !== 3'b100) begin n_fail++; $display("FAIL overrun error/busy/cmd_valid got=%b want=100", {error, busy, cmd_valid}); end
    load_demo();
  endtask

  task automatic test_reset_restart();
    int cyc;
    do_reset();
    cmd_ready = 1'b1; op_ready = 1'b1;
    pulse_start(32'd0);
    cyc = 0;
    while (op_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_cmp++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL rst_reach_oper op_valid got=%b want=1", op_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({op_valid, cmd_valid, busy, op_nwords, op_last} !== 7'd0 || op_data !== 128'd0 || fetch_pc !== 32'd0 || addr2 !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset got op_valid=%b cmd_valid=%b busy=%b nwords=%0d data=%h pc=%0d", op_valid, cmd_valid, busy, op_nwords, op_data, fetch_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b0;
    @(negedge clk);
    pulse_start(32'd18);
    n_cmp++; if ({busy, fetch_pc} !== {1'b1, 32'd18}) begin n_fail++; $display("FAIL restart_pc busy=%b pc=%0d want=1 pc=18", busy, fetch_pc); end
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_opcode, cmd_count} !== {1'b1, 8'h04, 5'd3}) begin n_fail++; $display("FAIL restart_hdr got=%b/%h/%0d want=1/04/3", cmd_valid, cmd_opcode, cmd_count); end
    pulse_start(32'd0);
    @(negedge clk);
    n_cmp++; if ({cmd_valid, cmd_opcode, fetch_pc} !== {1'b1, 8'h04, 32'd18}) begin n_fail++; $display("FAIL start_while_busy got=%b/%h pc=%0d want=1/04 pc=18", cmd_valid, cmd_opcode, fetch_pc); end
  endtask

  initial begin
    test_reset();
    test_cmd_backpressure();
    test_demo();
    test_op_backpressure();
    test_malformed();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
